// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the sequential 8x8 multiplier built on one 4x4 unit.
// Contents: quadrant/operand/result widths, FSM state enum, captured-request payload.
package mult_seq_pkg;

   localparam int unsigned QW = 4;        // quadrant (nibble) width
   localparam int unsigned OW = 8;        // operand width and 4x4 partial-product width
   localparam int unsigned RW = 16;       // full product width
   localparam int unsigned CW = 8;        // delivered-result counter width
   localparam int unsigned NQ = 4;        // number of quadrants / partial products

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PP0  = 3'd1,
      PP1  = 3'd2,
      PP2  = 3'd3,
      PP3  = 3'd4,
      DONE = 3'd5
   } state_t;

   // Request fields frozen at accept time
   typedef struct packed {
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic          mode;
      logic [NQ-1:0] cfg;
   } op_t;

endpackage

// File: rtl/mul4x4_trunc.sv
// Combinational 4x4 unsigned multiplier with optional truncation of the two LSBs.
// Ports: a, b   - 4-bit factors
//        trunc  - when 1, product bits [1:0] are forced to 0
//        p_c    - 8-bit product (combinational)
module mul4x4_trunc
   import mult_seq_pkg::*;
(
   input  logic [QW-1:0] a,
   input  logic [QW-1:0] b,
   input  logic          trunc,
   output logic [OW-1:0] p_c
);

   logic [OW-1:0] prod_c;

   assign prod_c = OW'(a) * OW'(b);
   assign p_c    = trunc ? {prod_c[OW-1:2], 2'b00} : prod_c;

endmodule

// File: rtl/mult_8x8_seq_sched.sv
// Sequential 8x8 multiplier: one shared 4x4 unit evaluates one quadrant per cycle
// (PP0..PP3); partial products are summed (mode 0) or OR-combined (mode 1).
// Ports: clk, rst_n           - clock, async active-low reset
//        in_valid/in_ready    - request handshake; A, B, mode, cfg_approx captured on accept
//        out_valid/out_ready  - result handshake; R held stable in DONE until taken
//        busy                 - high whenever not IDLE
//        done_cnt             - count of delivered results, wraps
module mult_8x8_seq_sched
   import mult_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [OW-1:0] A,
   input  logic [OW-1:0] B,
   input  logic          mode,
   input  logic [NQ-1:0] cfg_approx,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] R,
   output logic          busy,
   output logic [CW-1:0] done_cnt
);

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [RW-1:0] acc_q, acc_d;
   logic [CW-1:0] done_cnt_d;
   logic          out_valid_d, in_ready_d, busy_d;

   logic [QW-1:0] qa, qb;
   logic          trunc;
   logic [OW-1:0] pp_c;
   logic [RW-1:0] pp_sh;
   logic [RW-1:0] acc_next;

   mul4x4_trunc u_mul (
      .a     (qa),
      .b     (qb),
      .trunc (trunc),
      .p_c   (pp_c)
   );

   // Quadrant select: operand nibbles, truncate enable and weight for the current PP state
   always_comb begin
      qa    = op_q.a[QW-1:0];
      qb    = op_q.b[QW-1:0];
      trunc = op_q.cfg[0];
      pp_sh = RW'(pp_c);
      case (state_q)
         PP1: begin
            qb    = op_q.b[OW-1:QW];
            trunc = op_q.cfg[1];
            pp_sh = RW'(pp_c) << QW;
         end
         PP2: begin
            qa    = op_q.a[OW-1:QW];
            trunc = op_q.cfg[2];
            pp_sh = RW'(pp_c) << QW;
         end
         PP3: begin
            qa    = op_q.a[OW-1:QW];
            qb    = op_q.b[OW-1:QW];
            trunc = op_q.cfg[3];
            pp_sh = RW'(pp_c) << (2 * QW);
         end
         default: ;
      endcase
   end

   // Exact add cannot overflow 16 bits; OR mode is the cheap approximate combine
   assign acc_next = op_q.mode ? (acc_q | pp_sh) : (acc_q + pp_sh);

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      acc_d      = acc_q;
      done_cnt_d = done_cnt;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d.a    = A;
               op_d.b    = B;
               op_d.mode = mode;
               op_d.cfg  = cfg_approx;
               acc_d     = '0;
               state_d   = PP0;
            end
         end
         PP0: begin
            acc_d   = acc_next;
            state_d = PP1;
         end
         PP1: begin
            acc_d   = acc_next;
            state_d = PP2;
         end
         PP2: begin
            acc_d   = acc_next;
            state_d = PP3;
         end
         PP3: begin
            acc_d   = acc_next;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d    = IDLE;
               done_cnt_d = done_cnt + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         done_cnt  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         done_cnt  <= done_cnt_d;
         out_valid <= out_valid_d;
         in_ready  <= in_ready_d;
         busy      <= busy_d;
      end
   end

   // The accumulator is the result register; only meaningful in DONE
   assign R = acc_q;

endmodule

// File: tb/tb_mult_8x8_seq_sched.sv
// Self-checking bench for mult_8x8_seq_sched: directed vectors, random operands
// against an arithmetic reference, result stall, reset abort and back-to-back traffic.
module tb_mult_8x8_seq_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  A;
   logic [7:0]  B;
   logic        mode;
   logic [3:0]  cfg_approx;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] R;
   logic        busy;
   logic [7:0]  done_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   mult_8x8_seq_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .mode       (mode),
      .cfg_approx (cfg_approx),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .R          (R),
      .busy       (busy),
      .done_cnt   (done_cnt)
   );

   always #5 clk = ~clk;

   // Reference: split operands into nibbles, multiply, optionally clear two LSBs,
   // then weight each partial product and either sum or OR them.
   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic m, input logic [3:0] cfg);
      int p[4];
      int w[4];
      int res;
      int al, ah, bl, bh;
      al = int'(a) % 16;  ah = int'(a) / 16;
      bl = int'(b) % 16;  bh = int'(b) / 16;
      p[0] = al * bl;  w[0] = 1;
      p[1] = al * bh;  w[1] = 16;
      p[2] = ah * bl;  w[2] = 16;
      p[3] = ah * bh;  w[3] = 256;
      res = 0;
      for (int i = 0; i < 4; i++) begin
         if (cfg[i]) p[i] = p[i] - (p[i] % 4);
         if (m) res = res | (p[i] * w[i]);
         else   res = res + (p[i] * w[i]);
      end
      return 16'(res);
   endfunction

   // Issue one request and wait for its result; lat counts negedges from the accept edge
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                         input logic [3:0] cfg, output logic [15:0] r, output int lat);
      int w;
      lat = 0;
      r   = '0;
      w   = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL run_op_ready_timeout in_ready=%b required 1", in_ready);
         return;
      end
      A = a; B = b; mode = m; cfg_approx = cfg; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      A          = 8'($urandom);
      B          = 8'($urandom);
      mode       = 1'($urandom);
      cfg_approx = 4'($urandom);
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      if (!out_valid) begin
         n_checks++; n_fail++;
         $display("FAIL run_op_result_timeout out_valid=%b required 1", out_valid);
      end
      r = R;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; mode = 1'b0; cfg_approx = '0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
      n_checks++;
      if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done_cnt got %0d expected 0", done_cnt); end
      n_checks++;
      if (R !== 16'h0000) begin n_fail++; $display("FAIL reset_acc got %h expected 0000", R); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      exp_cnt = 0;
   endtask

   task automatic test_directed();
      logic [7:0]  ta[4];
      logic [7:0]  tb[4];
      logic        tm[4];
      logic [3:0]  tc[4];
      logic [15:0] te[4];
      logic [15:0] r;
      int          lat;
      ta = '{8'h12, 8'hFF, 8'hFF, 8'hFF};
      tb = '{8'h34, 8'hFF, 8'hFF, 8'hFF};
      tm = '{1'b0, 1'b0, 1'b0, 1'b1};
      tc = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};
      te = '{16'h03A8, 16'hFE01, 16'hFE00, 16'hEFF1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], tm[i], tc[i], r, lat);
         n_checks++;
         if (r !== te[i]) begin n_fail++; $display("FAIL dir_R[%0d] got %h expected %h", i, r, te[i]); end
         n_checks++;
         if (lat != 5) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d expected 5", i, lat); end
         @(negedge clk);
         exp_cnt++;
         n_checks++;
         if (done_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL dir_done_cnt[%0d] got %0d expected %0d", i, done_cnt, exp_cnt); end
         n_checks++;
         if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir_out_valid_drop[%0d] got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_random();
      logic [7:0]  a, b;
      logic        m;
      logic [3:0]  c;
      logic [15:0] r, e;
      int          lat;
      int          bad;
      bad = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom); b = 8'($urandom); m = 1'($urandom); c = 4'($urandom);
         if (i < 4) begin a = 8'hFF; b = 8'hFF; m = 1'b0; c = 4'b1111; end
         e = model(a, b, m, c);
         run_op(a, b, m, c, r, lat);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL rand_R a=%h b=%h mode=%b cfg=%b got %h expected %h", a, b, m, c, r, e);
         end
         if (lat != 5) bad++;
         exp_cnt++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL rand_latency ops_off=%0d expected 0", bad); end
      @(negedge clk);
      n_checks++;
      if (done_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rand_done_cnt got %0d expected %0d", done_cnt, exp_cnt); end
   endtask

   task automatic test_stall();
      logic [15:0] r, e, hold;
      int          lat;
      logic [7:0]  a, b;
      a = 8'($urandom); b = 8'($urandom);
      e = model(a, b, 1'b0, 4'b0000);
      out_ready = 1'b0;
      run_op(a, b, 1'b0, 4'b0000, r, lat);
      hold = r;
      n_checks++;
      if (r !== e) begin n_fail++; $display("FAIL stall_R got %h expected %h", r, e); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         A = 8'($urandom); B = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || R !== e || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] out_valid=%b R=%h in_ready=%b expected 1 %h 0", i, out_valid, R, in_ready, e);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
      n_checks++;
      if (done_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL stall_done_cnt got %0d expected %0d", done_cnt, exp_cnt); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_no_queue[%0d] busy=%b expected 0", i, busy); end
      end
      n_checks++;
      if (hold !== e) begin n_fail++; $display("FAIL stall_capture got %h expected %h", hold, e); end
   endtask

   task automatic test_reset_abort();
      logic [15:0] r;
      int          lat;
      int          seen;
      @(negedge clk);
      A = 8'h5A; B = 8'hC3; mode = 1'b0; cfg_approx = 4'b0000; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_pp2 got %b expected 1", busy); end
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL abort_async out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
      end
      n_checks++;
      if (done_cnt !== 8'd0 || R !== 16'h0000) begin
         n_fail++; $display("FAIL abort_regs done_cnt=%0d R=%h expected 0 0000", done_cnt, R);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen++;
      end
      n_checks++;
      if (seen != 0) begin n_fail++; $display("FAIL abort_no_result out_valid_cycles=%0d expected 0", seen); end
      out_ready = 1'b1;
      run_op(8'h02, 8'h03, 1'b0, 4'b0000, r, lat);
      n_checks++;
      if (r !== 16'h0006) begin n_fail++; $display("FAIL abort_next_R got %h expected 0006", r); end
      @(negedge clk);
      exp_cnt++;
      n_checks++;
      if (done_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL abort_done_cnt got %0d expected %0d", done_cnt, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] q[$];
      int          acc_at[$];
      logic [15:0] e;
      int          n_acc, n_out, k, bad_gap, bad_r;
      bit          saw255;
      n_acc = 0; n_out = 0; k = 0; bad_gap = 0; bad_r = 0; saw255 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      out_ready = 1'b1;
      while (n_out < 256 && k < 2000) begin
         @(negedge clk);
         k++;
         if (done_cnt === 8'd255) saw255 = 1'b1;
         if (out_valid) begin
            if (q.size() == 0) begin
               bad_r++;
            end else begin
               e = q.pop_front();
               if (R !== e) begin
                  bad_r++;
                  if (bad_r < 5) $display("FAIL b2b_R[%0d] got %h expected %h", n_out, R, e);
               end
            end
            n_out++;
         end
         A = 8'($urandom); B = 8'($urandom); mode = 1'($urandom); cfg_approx = 4'($urandom);
         in_valid = (n_acc < 256);
         if (in_valid && in_ready) begin
            q.push_back(model(A, B, mode, cfg_approx));
            acc_at.push_back(k);
            n_acc++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (n_out != 256) begin n_fail++; $display("FAIL b2b_count got %0d results expected 256", n_out); end
      n_checks++;
      if (bad_r != 0) begin n_fail++; $display("FAIL b2b_results wrong=%0d expected 0", bad_r); end
      for (int i = 1; i < acc_at.size(); i++)
         if (acc_at[i] - acc_at[i-1] != 6) bad_gap++;
      n_checks++;
      if (bad_gap != 0) begin n_fail++; $display("FAIL b2b_spacing irregular_gaps=%0d expected 0", bad_gap); end
      @(negedge clk);
      n_checks++;
      if (done_cnt !== 8'd0 || !saw255) begin
         n_fail++; $display("FAIL b2b_wrap done_cnt=%0d saw255=%b expected 0 1", done_cnt, saw255);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_stall();
      test_reset_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
